// File: rtl/hazard_ctrl_if.sv
// Hazard interface between the decoder/pipeline and the hazard controller.
// master: pipeline side. It drives the D-stage operand and destination info,
//         and it consumes the stall, the forwarding selects and W_A3.
// slave : hazard_ctrl.
interface hazard_ctrl_if #(
    parameter int AW = 5,
    parameter int TW = 2
);
    logic [AW-1:0] D_rs;
    logic [AW-1:0] D_rt;
    logic [TW-1:0] Tuse_rs;
    logic [TW-1:0] Tuse_rt;
    logic [AW-1:0] D_A3;
    logic [TW-1:0] D_Tnew;
    logic          stall;
    logic [1:0]    fwd_D_rs;
    logic [1:0]    fwd_D_rt;
    logic [1:0]    fwd_E_rs;
    logic [1:0]    fwd_E_rt;
    logic          fwd_M_rt;
    logic [AW-1:0] W_A3;

    modport master (
        output D_rs, D_rt, Tuse_rs, Tuse_rt, D_A3, D_Tnew,
        input  stall, fwd_D_rs, fwd_D_rt, fwd_E_rs, fwd_E_rt, fwd_M_rt, W_A3
    );

    modport slave (
        input  D_rs, D_rt, Tuse_rs, Tuse_rt, D_A3, D_Tnew,
        output stall, fwd_D_rs, fwd_D_rt, fwd_E_rs, fwd_E_rt, fwd_M_rt, W_A3
    );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall and forwarding control for a five-stage pipeline.
// This block tracks the A3, source registers and Tnew of each instruction in E, M and W.
// From that state it derives:
//   stall            - freeze PC/D, bubble into E
//   fwd_D_rs/rt      - 0 GRF, 1 from E, 2 from M
//   fwd_E_rs/rt      - 0 pipeline reg, 1 from M, 2 from W
//   fwd_M_rt         - 0 pipeline reg, 1 from W
//   W_A3             - GRF write address
// Ports:
//   clk   - rising-edge clock
//   reset - asynchronous reset, active low
//   hz    - hazard_ctrl_if slave modport

// Per-source-operand hazard check. The rs and rt operands each get one instance.
module hazard_src #(
    parameter int AW = 5,
    parameter int TW = 2
) (
    input  logic [AW-1:0] d_src,
    input  logic [TW-1:0] tuse,
    input  logic [AW-1:0] e_src,
    input  logic [AW-1:0] e_a3,
    input  logic [TW-1:0] e_tnew,
    input  logic [AW-1:0] m_a3,
    input  logic [TW-1:0] m_tnew,
    input  logic [AW-1:0] w_a3,
    output logic          stall,
    output logic [1:0]    fwd_d,
    output logic [1:0]    fwd_e
);
    logic d_hit_e, d_hit_m, e_hit_m, e_hit_w;

    // $0 is never a real producer. A nonzero source that matches implies a
    // nonzero A3.
    assign d_hit_e = (d_src != '0) && (e_a3 == d_src);
    assign d_hit_m = (d_src != '0) && (m_a3 == d_src);
    assign e_hit_m = (e_src != '0) && (m_a3 == e_src);
    assign e_hit_w = (e_src != '0) && (w_a3 == e_src);

    always_comb begin
        stall = (d_hit_e && (tuse < e_tnew)) || (d_hit_m && (tuse < m_tnew));

        // The nearest stage that is already producing wins.
        fwd_d = 2'd0;
        if (d_hit_e && e_tnew == '0)      fwd_d = 2'd1;
        else if (d_hit_m && m_tnew == '0) fwd_d = 2'd2;

        // W always has Tnew=0, so a match in W is always ready.
        fwd_e = 2'd0;
        if (e_hit_m && m_tnew == '0) fwd_e = 2'd1;
        else if (e_hit_w)            fwd_e = 2'd2;
    end
endmodule

module hazard_ctrl #(
    parameter int AW = 5,
    parameter int TW = 2
) (
    input logic         clk,
    input logic         reset,
    hazard_ctrl_if.slave hz
);
    logic [AW-1:0] E_rs, E_rt, E_A3, M_rt, M_A3, W_A3;
    logic [TW-1:0] E_Tnew, M_Tnew;

    // Index 0 holds rs and index 1 holds rt.
    logic [1:0][AW-1:0] d_src, e_src;
    logic [1:0][TW-1:0] tuse;
    logic [1:0]         stall_src;
    logic [1:0][1:0]    fwd_d, fwd_e;

    assign d_src = {hz.D_rt, hz.D_rs};
    assign e_src = {E_rt, E_rs};
    assign tuse  = {hz.Tuse_rt, hz.Tuse_rs};

    for (genvar g = 0; g < 2; g++) begin : g_src
        hazard_src #(.AW(AW), .TW(TW)) u_src (
            .d_src  (d_src[g]),
            .tuse   (tuse[g]),
            .e_src  (e_src[g]),
            .e_a3   (E_A3),
            .e_tnew (E_Tnew),
            .m_a3   (M_A3),
            .m_tnew (M_Tnew),
            .w_a3   (W_A3),
            .stall  (stall_src[g]),
            .fwd_d  (fwd_d[g]),
            .fwd_e  (fwd_e[g])
        );
    end

    logic stall;
    assign stall       = |stall_src;
    assign hz.stall    = stall;
    assign hz.fwd_D_rs = fwd_d[0];
    assign hz.fwd_D_rt = fwd_d[1];
    assign hz.fwd_E_rs = fwd_e[0];
    assign hz.fwd_E_rt = fwd_e[1];
    assign hz.fwd_M_rt = (W_A3 != '0) && (W_A3 == M_rt);
    assign hz.W_A3     = W_A3;

    // Tnew drops by one per stage and saturates at 0.
    logic [TW-1:0] e_tnew_dec;
    assign e_tnew_dec = (E_Tnew == '0) ? '0 : E_Tnew - TW'(1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            E_rs   <= '0;
            E_rt   <= '0;
            E_A3   <= '0;
            E_Tnew <= '0;
            M_rt   <= '0;
            M_A3   <= '0;
            M_Tnew <= '0;
            W_A3   <= '0;
        end else begin
            // On a stall, a bubble enters E. M and W keep advancing.
            if (stall) begin
                E_rs   <= '0;
                E_rt   <= '0;
                E_A3   <= '0;
                E_Tnew <= '0;
            end else begin
                E_rs   <= hz.D_rs;
                E_rt   <= hz.D_rt;
                E_A3   <= hz.D_A3;
                E_Tnew <= hz.D_Tnew;
            end
            M_rt   <= E_rt;
            M_A3   <= E_A3;
            M_Tnew <= e_tnew_dec;
            W_A3   <= M_A3;
        end
    end
endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_chk = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    hazard_ctrl_if #(.AW(5), .TW(2)) hz ();

    hazard_ctrl #(.AW(5), .TW(2)) u_dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hz)
    );

    // Reference model. The model keeps the instructions that issued into E
    // over the last three cycles, youngest first: [0]=E, [1]=M, [2]=W.
    // The Tnew of an instruction is its Tnew on entry minus its age, with a
    // floor of 0.
    typedef struct packed {
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] a3;
        logic [1:0] tnew;
    } instr_t;

    instr_t hist [3];

    function automatic int tn(int k);
        int t;
        t = int'(hist[k].tnew) - k;
        return (t < 0) ? 0 : t;
    endfunction

    function automatic bit m_stall_src(logic [4:0] s, logic [1:0] tu);
        if (s == 0) return 1'b0;
        for (int k = 0; k < 2; k++)
            if (hist[k].a3 == s && int'(tu) < tn(k)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit m_stall();
        return m_stall_src(hz.D_rs, hz.Tuse_rs) || m_stall_src(hz.D_rt, hz.Tuse_rt);
    endfunction

    function automatic int m_fwd_d(logic [4:0] s);
        if (s == 0) return 0;
        for (int k = 0; k < 2; k++)
            if (hist[k].a3 == s && tn(k) == 0) return k + 1;
        return 0;
    endfunction

    function automatic int m_fwd_e(logic [4:0] s);
        if (s == 0) return 0;
        if (hist[1].a3 == s && tn(1) == 0) return 1;
        if (hist[2].a3 == s) return 2;
        return 0;
    endfunction

    task automatic clear_model();
        for (int k = 0; k < 3; k++) hist[k] = '0;
    endtask

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive(input logic [4:0] rs, input logic [1:0] tr,
                         input logic [4:0] rt, input logic [1:0] tt,
                         input logic [4:0] a3, input logic [1:0] tn_in);
        hz.D_rs = rs; hz.Tuse_rs = tr;
        hz.D_rt = rt; hz.Tuse_rt = tt;
        hz.D_A3 = a3; hz.D_Tnew  = tn_in;
    endtask

    task automatic nop();
        drive(5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd0);
    endtask

    // Compare every output with the model at the negedge. Then advance the
    // model and cross the next posedge.
    task automatic tick();
        instr_t nxt;
        @(negedge clk);
        chk("m_stall",    int'(hz.stall),    int'(m_stall()));
        chk("m_fwd_D_rs", int'(hz.fwd_D_rs), m_fwd_d(hz.D_rs));
        chk("m_fwd_D_rt", int'(hz.fwd_D_rt), m_fwd_d(hz.D_rt));
        chk("m_fwd_E_rs", int'(hz.fwd_E_rs), m_fwd_e(hist[0].rs));
        chk("m_fwd_E_rt", int'(hz.fwd_E_rt), m_fwd_e(hist[0].rt));
        chk("m_fwd_M_rt", int'(hz.fwd_M_rt),
            int'(hist[2].a3 != 0 && hist[2].a3 == hist[1].rt));
        chk("m_W_A3",     int'(hz.W_A3),     int'(hist[2].a3));
        if (reset) begin
            nxt = m_stall() ? '0 : instr_t'{hz.D_rs, hz.D_rt, hz.D_A3, hz.D_Tnew};
            hist[2] = hist[1];
            hist[1] = hist[0];
            hist[0] = nxt;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic flush();
        nop();
        repeat (3) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_model();
        drive(5'd0, 2'd3, 5'd0, 2'd3, 5'd5, 2'd1);
        @(posedge clk);
        #1;
        // While reset is held, all outputs are zero.
        chk("rst_stall", int'(hz.stall), 0);
        chk("rst_fwd", int'({hz.fwd_D_rs, hz.fwd_D_rt, hz.fwd_E_rs, hz.fwd_E_rt, hz.fwd_M_rt}), 0);
        chk("rst_W_A3", int'(hz.W_A3), 0);
        tick();
        reset = 1'b1;
        tick();
        tick();
        chk("rst_W_A3_e2", int'(hz.W_A3), 0);
        tick();
        chk("rst_W_A3_e3", int'(hz.W_A3), 5);
        flush();

        // Load-use case
        drive(5'd0, 2'd3, 5'd0, 2'd3, 5'd8, 2'd2); tick();
        drive(5'd8, 2'd1, 5'd0, 2'd3, 5'd10, 2'd1); #1;
        chk("lu_stall1", int'(hz.stall), 1);
        tick();
        chk("lu_stall2", int'(hz.stall), 0);
        tick();
        chk("lu_fwd_E_rs", int'(hz.fwd_E_rs), 2);
        flush();

        // A branch that follows an ALU op
        drive(5'd0, 2'd3, 5'd0, 2'd3, 5'd9, 2'd1); tick();
        drive(5'd9, 2'd0, 5'd0, 2'd3, 5'd0, 2'd0); #1;
        chk("br_stall1", int'(hz.stall), 1);
        tick();
        chk("br_stall2", int'(hz.stall), 0);
        chk("br_fwd_D_rs", int'(hz.fwd_D_rs), 2);
        flush();

        // Two producers of $4. The younger producer wins.
        drive(5'd0, 2'd3, 5'd0, 2'd3, 5'd4, 2'd1); tick();
        drive(5'd0, 2'd3, 5'd0, 2'd3, 5'd4, 2'd1); tick();
        drive(5'd0, 2'd3, 5'd4, 2'd1, 5'd5, 2'd1); #1;
        chk("dp_stall", int'(hz.stall), 0);
        tick();
        chk("dp_fwd_E_rt", int'(hz.fwd_E_rt), 1);
        flush();

        // Writes to $0 never stall and never forward.
        drive(5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd1); tick();
        drive(5'd0, 2'd0, 5'd0, 2'd3, 5'd0, 2'd0); #1;
        chk("z_stall", int'(hz.stall), 0);
        chk("z_fwd_D_rs", int'(hz.fwd_D_rs), 0);
        tick();
        flush();

        // Store data forwarded into M
        drive(5'd0, 2'd3, 5'd0, 2'd3, 5'd3, 2'd2); tick();
        drive(5'd0, 2'd3, 5'd3, 2'd2, 5'd0, 2'd0); #1;
        chk("st_stall", int'(hz.stall), 0);
        tick();
        nop();
        tick();
        chk("st_fwd_M_rt", int'(hz.fwd_M_rt), 1);
        flush();

        // A consumer with Tuse 0 behind a load stalls for 2 cycles.
        drive(5'd0, 2'd3, 5'd0, 2'd3, 5'd7, 2'd2); tick();
        drive(5'd0, 2'd3, 5'd7, 2'd0, 5'd0, 2'd0); #1;
        chk("ld2_stall1", int'(hz.stall), 1);
        tick();
        chk("ld2_stall2", int'(hz.stall), 1);
        tick();
        chk("ld2_stall3", int'(hz.stall), 0);
        flush();

        // Reset while a stall is active. The stall drops asynchronously.
        drive(5'd0, 2'd3, 5'd0, 2'd3, 5'd8, 2'd2); tick();
        drive(5'd8, 2'd1, 5'd0, 2'd3, 5'd0, 2'd0); #1;
        chk("ms_stall_pre", int'(hz.stall), 1);
        reset = 1'b0; #1;
        chk("ms_stall_rst", int'(hz.stall), 0);
        clear_model();
        tick();
        reset = 1'b1;
        flush();

        // Random traffic. Registers are drawn from a small pool so that
        // hazards occur often. D inputs are held while the model stalls.
        for (int i = 0; i < 600; i++) begin
            if (!m_stall())
                drive(5'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
                      5'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
                      5'($urandom_range(0, 7)), 2'($urandom_range(0, 2)));
            if ($urandom_range(0, 59) == 0) begin
                reset = 1'b0; #1;
                chk("rnd_rst_stall", int'(hz.stall), 0);
                chk("rnd_rst_W_A3", int'(hz.W_A3), 0);
                clear_model();
                tick();
                reset = 1'b1;
            end else begin
                tick();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
